// File: rtl/fighter_anim_seq.sv
// Per-fighter animation sequencer: one state/sub-frame step per rising edge of frame_clk.
// Optional attack input buffer is enabled by defining ANIM_INPUT_BUFFER_EN.
module fighter_anim_seq #(
    parameter int CNT_W     = 8,
    parameter int METER_W   = 10,
    parameter int METER_MAX = 200,
    parameter int LOOP_T    = 8,
    parameter int ATK_T1    = 3,
    parameter int ATK_T2    = 10,
    parameter int ATK_T3    = 15,
    parameter int ATK_HIT   = 4,
    parameter int JMP_T1    = 5,
    parameter int JMP_T2    = 15,
    parameter int JMP_T3    = 55,
    parameter int JMP_T4    = 75,
    parameter int SPC_T     = 15,
    parameter int SPC_GEN   = 44,
    parameter int CP_T      = 5,
    parameter int REC_T     = 6,
    parameter int STUN_T    = 12,
    parameter int BLK_T     = 6,
    parameter int KO_T      = 10
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_clk,
    input  logic [6:0]         key,
    input  logic               isdead,
    input  logic               got_hit,
    input  logic [METER_W-1:0] meter,
    output logic [3:0]         anim_state,
    output logic [1:0]         anim_frame,
    output logic [CNT_W-1:0]   phase_cnt,
    output logic               hit,
    output logic               gen,
    output logic               blocking
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WALK    = 4'd1,
        ST_PUNCH   = 4'd2,
        ST_KICK    = 4'd3,
        ST_RECOVER = 4'd4,
        ST_CROUCH  = 4'd5,
        ST_CPUNCH  = 4'd6,
        ST_JUMP    = 4'd7,
        ST_SPECIAL = 4'd8,
        ST_STUN    = 4'd9,
        ST_BLOCK   = 4'd10,
        ST_KO      = 4'd11
    } state_t;

    localparam logic [METER_W-1:0] C_METER_MAX = METER_W'(METER_MAX);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_LOOP1    = CNT_W'(LOOP_T);
    localparam logic [CNT_W-1:0] C_LOOP2    = CNT_W'(2 * LOOP_T);
    localparam logic [CNT_W-1:0] C_LOOP_END = CNT_W'(3 * LOOP_T - 1);
    localparam logic [CNT_W-1:0] C_ATK1     = CNT_W'(ATK_T1);
    localparam logic [CNT_W-1:0] C_ATK2     = CNT_W'(ATK_T2);
    localparam logic [CNT_W-1:0] C_ATK3     = CNT_W'(ATK_T3);
    localparam logic [CNT_W-1:0] C_ATK_HIT  = CNT_W'(ATK_HIT);
    localparam logic [CNT_W-1:0] C_JMP1     = CNT_W'(JMP_T1);
    localparam logic [CNT_W-1:0] C_JMP2     = CNT_W'(JMP_T2);
    localparam logic [CNT_W-1:0] C_JMP3     = CNT_W'(JMP_T3);
    localparam logic [CNT_W-1:0] C_JMP4     = CNT_W'(JMP_T4);
    localparam logic [CNT_W-1:0] C_SPC1     = CNT_W'(SPC_T);
    localparam logic [CNT_W-1:0] C_SPC2     = CNT_W'(2 * SPC_T);
    localparam logic [CNT_W-1:0] C_SPC3     = CNT_W'(3 * SPC_T);
    localparam logic [CNT_W-1:0] C_SPC_GEN  = CNT_W'(SPC_GEN);
    localparam logic [CNT_W-1:0] C_CP       = CNT_W'(CP_T);
    localparam logic [CNT_W-1:0] C_REC      = CNT_W'(REC_T);
    localparam logic [CNT_W-1:0] C_STUN     = CNT_W'(STUN_T);
    localparam logic [CNT_W-1:0] C_BLK      = CNT_W'(BLK_T);
    localparam logic [CNT_W-1:0] C_KO       = CNT_W'(KO_T);

    logic             frame_q, frame_d;
    logic             frame_dly_q, frame_dly_d;
    logic             hit_pend_q, hit_pend_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [1:0]       anim_frame_q, anim_frame_d;
    logic             hit_q, hit_d;
    logic             gen_q, gen_d;
    logic             blocking_q, blocking_d;

    logic             tick;
    logic             hit_now;
    logic [CNT_W-1:0] cnt_inc;
    state_t           base_next;
    state_t           nxt_state;
    state_t           rec_exit;
    logic             restart;

    // A got_hit arriving on the tick cycle itself is used directly, so nothing is left pending.
    assign tick       = frame_q & ~frame_dly_q;
    assign hit_now    = hit_pend_q | got_hit;
    assign hit_pend_d = tick ? 1'b0 : hit_now;
    assign frame_d    = frame_clk;
    assign frame_dly_d = frame_q;
    assign cnt_inc    = (&phase_cnt_q) ? phase_cnt_q : phase_cnt_q + C_ONE;

    always_comb begin
        base_next = ST_IDLE;
        if (isdead)                               base_next = ST_KO;
        else if (hit_now)                         base_next = key[3] ? ST_BLOCK : ST_STUN;
        else if (key[6])                          base_next = ST_JUMP;
        else if (key[5])                          base_next = ST_CROUCH;
        else if (key[1])                          base_next = ST_KICK;
        else if (key[2])                          base_next = ST_PUNCH;
        else if (key[0] && meter == C_METER_MAX)  base_next = ST_SPECIAL;
        else if (key[3] || key[4])                base_next = ST_WALK;
    end

`ifdef ANIM_INPUT_BUFFER_EN
    logic buf_kick_q, buf_kick_d;
    logic buf_punch_q, buf_punch_d;
    logic in_atk, kick_seen, punch_seen;

    always_comb begin
        in_atk     = (state_q == ST_PUNCH) || (state_q == ST_KICK) || (state_q == ST_RECOVER);
        kick_seen  = buf_kick_q  | (tick & in_atk & key[1]);
        punch_seen = buf_punch_q | (tick & in_atk & key[2]);
        rec_exit   = kick_seen ? ST_KICK : (punch_seen ? ST_PUNCH : ST_IDLE);
    end

    // Drop the latch when leaving RECOVER (it was just consumed) or on any reaction state.
    always_comb begin
        buf_kick_d  = buf_kick_q;
        buf_punch_d = buf_punch_q;
        if (tick) begin
            if ((state_d == ST_KO) || (state_d == ST_STUN) || (state_d == ST_BLOCK) ||
                (state_q == ST_RECOVER && state_d != ST_RECOVER)) begin
                buf_kick_d  = 1'b0;
                buf_punch_d = 1'b0;
            end else begin
                buf_kick_d  = kick_seen;
                buf_punch_d = punch_seen;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            buf_kick_q  <= 1'b0;
            buf_punch_q <= 1'b0;
        end else begin
            buf_kick_q  <= buf_kick_d;
            buf_punch_q <= buf_punch_d;
        end
    end
`else
    assign rec_exit = ST_IDLE;
`endif

    always_comb begin
        nxt_state = state_q;
        restart   = 1'b0;
        case (state_q)
            ST_IDLE, ST_WALK: begin
                nxt_state = base_next;
                if (base_next == state_q && phase_cnt_q == C_LOOP_END) restart = 1'b1;
            end
            ST_CROUCH: begin
                if (isdead)        nxt_state = ST_KO;
                else if (hit_now)  nxt_state = key[3] ? ST_BLOCK : ST_STUN;
                else if (key[6])   nxt_state = ST_JUMP;
                else if (!key[5])  nxt_state = ST_IDLE;
                else if (key[2])   nxt_state = ST_CPUNCH;
                else               nxt_state = ST_CROUCH;
            end
            ST_PUNCH, ST_KICK: if (phase_cnt_q == C_ATK3) nxt_state = ST_RECOVER;
            ST_RECOVER:        if (phase_cnt_q == C_REC)  nxt_state = rec_exit;
            ST_CPUNCH:         if (phase_cnt_q == C_CP)   nxt_state = ST_CROUCH;
            ST_JUMP:           if (phase_cnt_q == C_JMP4) nxt_state = ST_IDLE;
            ST_SPECIAL:        if (phase_cnt_q == C_SPC3) nxt_state = ST_IDLE;
            ST_STUN: begin
                if (hit_now)                     restart   = 1'b1;
                else if (phase_cnt_q == C_STUN)  nxt_state = ST_IDLE;
            end
            ST_BLOCK: begin
                if (hit_now)                     restart   = 1'b1;
                else if (phase_cnt_q == C_BLK)   nxt_state = ST_IDLE;
            end
            ST_KO: if (!isdead && phase_cnt_q >= C_KO) nxt_state = ST_IDLE;
            default: nxt_state = ST_IDLE;
        endcase
        if (isdead && state_q != ST_KO) nxt_state = ST_KO;

        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        if (tick) begin
            state_d     = nxt_state;
            phase_cnt_d = (nxt_state != state_q || restart) ? '0 : cnt_inc;
        end
    end

    // Outputs derive from the next state, so they are registered alongside it and hold between ticks.
    always_comb begin
        anim_frame_d = 2'd0;
        case (state_d)
            ST_IDLE, ST_WALK: begin
                if (phase_cnt_d >= C_LOOP2)      anim_frame_d = 2'd2;
                else if (phase_cnt_d >= C_LOOP1) anim_frame_d = 2'd1;
            end
            ST_PUNCH, ST_KICK: begin
                if (phase_cnt_d >= C_ATK2)       anim_frame_d = 2'd2;
                else if (phase_cnt_d >= C_ATK1)  anim_frame_d = 2'd1;
            end
            ST_JUMP: begin
                if (phase_cnt_d >= C_JMP3)       anim_frame_d = 2'd3;
                else if (phase_cnt_d >= C_JMP2)  anim_frame_d = 2'd2;
                else if (phase_cnt_d >= C_JMP1)  anim_frame_d = 2'd1;
            end
            ST_SPECIAL: begin
                if (phase_cnt_d >= C_SPC3)       anim_frame_d = 2'd3;
                else if (phase_cnt_d >= C_SPC2)  anim_frame_d = 2'd2;
                else if (phase_cnt_d >= C_SPC1)  anim_frame_d = 2'd1;
            end
            ST_KO: if (phase_cnt_d >= C_KO) anim_frame_d = 2'd1;
            default: anim_frame_d = 2'd0;
        endcase
        hit_d = ((state_d == ST_PUNCH || state_d == ST_KICK) && phase_cnt_d == C_ATK_HIT) ||
                (state_d == ST_CPUNCH && phase_cnt_d == C_ONE);
        gen_d      = (state_d == ST_SPECIAL) && (phase_cnt_d == C_SPC_GEN);
        blocking_d = (state_d == ST_BLOCK);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_q      <= 1'b0;
            frame_dly_q  <= 1'b0;
            hit_pend_q   <= 1'b0;
            state_q      <= ST_IDLE;
            phase_cnt_q  <= '0;
            anim_frame_q <= 2'd0;
            hit_q        <= 1'b0;
            gen_q        <= 1'b0;
            blocking_q   <= 1'b0;
        end else begin
            frame_q      <= frame_d;
            frame_dly_q  <= frame_dly_d;
            hit_pend_q   <= hit_pend_d;
            state_q      <= state_d;
            phase_cnt_q  <= phase_cnt_d;
            anim_frame_q <= anim_frame_d;
            hit_q        <= hit_d;
            gen_q        <= gen_d;
            blocking_q   <= blocking_d;
        end
    end

    assign anim_state = state_q;
    assign anim_frame = anim_frame_q;
    assign phase_cnt  = phase_cnt_q;
    assign hit        = hit_q;
    assign gen        = gen_q;
    assign blocking   = blocking_q;

endmodule

// File: doc/fighter_anim_seq.md
# fighter_anim_seq

Parametrised per-fighter animation sequencer, successor to the fixed-timing character FSM. It advances one animation tick per rising edge of `frame_clk`. It drives the sprite selector with a state code and sub-frame index, and drives the hit-detect and projectile logic with strobes. Compared with the previous generation, it adds:
- parametrised phase timing and meter width
- hit-stun and block reactions
- KO with top priority
- an optional attack input buffer

## Interface
Parameters:
- `CNT_W`, 8: width of the phase counter.
- `METER_W`, 10: width of the `meter` input.
- `METER_MAX`, 200: meter value that enables the special move.
- `LOOP_T`, 8: ticks per sub-frame for idle and walk; 3 sub-frames per loop.
- `ATK_T1` / `ATK_T2` / `ATK_T3`, 3 / 10 / 15: cumulative tick counts ending punch and kick sub-frames 0, 1 and 2.
- `ATK_HIT`, 4: tick count at which a punch or kick lands.
- `JMP_T1` / `JMP_T2` / `JMP_T3` / `JMP_T4`, 5 / 15 / 55 / 75: cumulative jump sub-frame ends.
- `SPC_T`, 15: ticks per special sub-frame; 3 sub-frames.
- `SPC_GEN`, 44: special tick count at which the projectile spawns.
- `CP_T`, 5: crouch-punch duration.
- `REC_T`, 6: attack recovery duration.
- `STUN_T`, 12: hit-stun duration.
- `BLK_T`, 6: block-stun duration.
- `KO_T`, 10: KO fall duration.

Ports:
- `Clk` in 1: system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `frame_clk` in 1: frame strobe, asynchronous level.
- `key` in 7: action inputs.
  - bit 0 special, bit 1 kick, bit 2 punch, bit 3 back, bit 4 forward, bit 5 crouch, bit 6 jump.
- `isdead` in 1: health is zero.
- `got_hit` in 1: opponent attack connected; pulse of any width ≥ 1 `Clk`.
- `meter` in `METER_W`: current special meter.
- `anim_state` out 4: state code.
- `anim_frame` out 2: sub-frame index, 0–3.
- `phase_cnt` out `CNT_W`: ticks elapsed in the current state.
- `hit` out 1: attack-active strobe.
- `gen` out 1: projectile spawn strobe.
- `blocking` out 1: high while in BLOCK.

## Operation
State codes:

IDLE=0, WALK=1, PUNCH=2, KICK=3, RECOVER=4, CROUCH=5, CPUNCH=6, JUMP=7, SPECIAL=8, STUN=9, BLOCK=10, KO=11.

Ticks and the phase counter:
- A tick is a registered rising edge of `frame_clk`, detected via a one-flop delay. State, counter and strobe registers update only on tick cycles.
- On every state change, `phase_cnt` loads 0. Otherwise it increments by 1 per tick and saturates at all-ones.

Hit pending:
- A `got_hit` high on any `Clk` cycle sets a `hit_pend` flag. The flag is consumed (cleared) on the next tick.

Priority in IDLE, WALK and CROUCH, highest first:
1. `isdead` → KO.
2. `hit_pend` → BLOCK if `key[3]`, else STUN.
3. `key[6]` → JUMP.
4. `key[5]` → CROUCH.
5. `key[1]` → KICK.
6. `key[2]` → PUNCH.
7. `key[0]` and `meter == METER_MAX` → SPECIAL.
8. `key[3]` or `key[4]` → WALK.
9. Otherwise → IDLE.

Exceptions to the priority list:
- In CROUCH, `key[2]` selects CPUNCH instead.
- In CROUCH, release of `key[5]` returns to IDLE.

Loops:
- IDLE and WALK: `anim_frame = phase_cnt / LOOP_T`.
- At `phase_cnt == 3*LOOP_T-1` the counter reloads 0 and the state is unchanged.

Attacks (PUNCH, KICK):
- `anim_frame` is 0, 1 or 2 by `ATK_T*` thresholds.
- At `phase_cnt == ATK_T3` → RECOVER.
- Attacks are uninterruptible except by `isdead` → KO.

RECOVER:
- At `REC_T` → IDLE.

CPUNCH:
- At `CP_T` → CROUCH.

JUMP:
- 4 sub-frames by `JMP_T*`.
- At `JMP_T4` → IDLE.

SPECIAL:
- `anim_frame = phase_cnt / SPC_T`.
- At `3*SPC_T` → IDLE.

STUN and BLOCK:
- At `STUN_T` or `BLK_T` respectively → IDLE.
- A new `hit_pend` during either state restarts the counter at 0 in the same state.

KO:
- `anim_frame` is 0 until `KO_T`, then 1.
- Stays in KO while `isdead` is high.
- Once `isdead` is low and `phase_cnt ≥ KO_T` → IDLE.
- `isdead` forces KO from every state except KO itself.

Strobes:
- `hit` is high for exactly one tick period when either:
  - in PUNCH or KICK with `phase_cnt == ATK_HIT`, or
  - in CPUNCH with `phase_cnt == 1`.
- `gen` is high for one tick period in SPECIAL with `phase_cnt == SPC_GEN`.

Arithmetic:
- All threshold compares are unsigned `CNT_W`-bit.
- Parameters must satisfy `3*SPC_T < 2^CNT_W`.

## Timing
Reset (`Reset_n` low, asynchronous):
- `anim_state` = IDLE, `anim_frame` = 0, `phase_cnt` = 0.
- `hit`, `gen`, `blocking` and `hit_pend` = 0.
- Edge-detect flop = 0, so a `frame_clk` that is high at release yields one tick.
- Reset asserted mid-attack or mid-KO returns to IDLE immediately.

Tick latency:
- `frame_clk` first sampled high at edge k → tick flag high in cycle k..k+1 → state and outputs update at edge k+1.
- Outputs are registered and hold between ticks.

`got_hit` and tick on the same cycle:
- The tick uses the new hit, and `hit_pend` is not left set.

`key` is sampled only on tick cycles; no debounce.

## Configuration
`ANIM_INPUT_BUFFER_EN`, when defined:
- A `key[1]` or `key[2]` press seen on any tick during PUNCH, KICK or RECOVER is latched. Kick wins if both are pressed.
- On RECOVER exit, the machine goes directly to KICK or PUNCH instead of IDLE, then clears the latch.
- The latch is cleared on KO, STUN, BLOCK or reset.

When not defined:
- No latch; RECOVER always exits to IDLE.

## Test plan
- Reset, then punch:
  - Hold `key[2]` for 1 tick from IDLE → PUNCH.
  - `hit` high only at `phase_cnt` 4.
  - `anim_frame` = 0, 1, 2 changes at ticks 3 and 10.
  - RECOVER at 15, IDLE 6 ticks later.
- Special gating:
  - `key[0]` with `meter` = 199 → stays IDLE.
  - `meter` = 200 → SPECIAL; `gen` pulses once at `phase_cnt` 44; IDLE at 45.
- Hit and block:
  - 1-`Clk` `got_hit` pulse between ticks, no keys → STUN on the next tick, IDLE after 12 ticks.
  - Same with `key[3]` held → BLOCK, `blocking` = 1, IDLE after 6 ticks.
- KO:
  - `isdead` asserted during JUMP at `phase_cnt` 20 → KO on the next tick.
  - `anim_frame` = 1 after 10 ticks.
  - Deassert `isdead` → IDLE on the next tick.
- Buffer:
  - With the macro defined, press `key[1]` during PUNCH tick 8 → KICK directly after RECOVER.
  - With the macro undefined → IDLE.
- Reset mid-operation:
  - `Reset_n` low during KICK `phase_cnt` 7 → all outputs 0 and IDLE asynchronously.
  - After release with `frame_clk` high, exactly one tick occurs.
